// File: rtl/calc_div_pkg.sv
// ---------------------------------------------------------------------------
// calc_div_pkg
//   Shared definitions for the layer-3 sequential signed divider.
//   - state_t            : divider control states (IDLE -> ITER -> FIX)
//   - *_WIDTH_DEF        : default operand widths, common with the layer-3
//                          pipelined multiplier wrapper
//   - CNT_WIDTH          : iteration counter width for the default dividend
//   - cnt_width()        : counter width for an arbitrary dividend width
// ---------------------------------------------------------------------------
package calc_div_pkg;

  localparam int DIVIDEND_WIDTH_DEF = 71;
  localparam int DIVISOR_WIDTH_DEF  = 13;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  // Counter must hold DIVIDEND_WIDTH-1; guard the degenerate 1-bit case.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int CNT_WIDTH = cnt_width(DIVIDEND_WIDTH_DEF);

endpackage : calc_div_pkg

// File: rtl/calculate_layer3_sdiv_step.sv
// ---------------------------------------------------------------------------
// calculate_layer3_sdiv_step
//   One combinational radix-2 restoring division step on unsigned magnitudes.
//   The {rem, quo} pair is shifted left by one; the bit leaving quo enters
//   rem. If the shifted remainder is not smaller than the divisor magnitude
//   the subtraction is kept and a 1 is shifted into the quotient LSB.
// Ports
//   rem_in       in   RW   partial remainder (magnitude)
//   quo_in       in   QW   dividend/quotient shift register (magnitude)
//   divisor_mag  in   RW   divisor magnitude
//   rem_out      out  RW   next partial remainder
//   quo_out      out  QW   next quotient shift register
// ---------------------------------------------------------------------------
module calculate_layer3_sdiv_step
  import calc_div_pkg::*;
#(
  parameter int QW = DIVIDEND_WIDTH_DEF,
  parameter int RW = DIVISOR_WIDTH_DEF
) (
  input  logic [RW-1:0] rem_in,
  input  logic [QW-1:0] quo_in,
  input  logic [RW-1:0] divisor_mag,
  output logic [RW-1:0] rem_out,
  output logic [QW-1:0] quo_out
);

  logic [RW:0]   rem_shift;
  logic [RW-1:0] rem_sub;
  logic          fits;

  // NOTE: every signal assigned in always_comb gets a value on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    rem_shift = {rem_in, quo_in[QW-1]};
    // The trial subtraction is RW+1 bits wide; its sign is the compare below,
    // and since a kept result is always < divisor_mag the low RW bits suffice.
    fits      = (rem_shift >= {1'b0, divisor_mag});
    rem_sub   = rem_shift[RW-1:0] - divisor_mag;
    rem_out   = fits ? rem_sub : rem_shift[RW-1:0];
    quo_out   = {quo_in[QW-2:0], fits};
  end

endmodule : calculate_layer3_sdiv_step

// File: rtl/calculate_layer3_sdiv_seq.sv
// ---------------------------------------------------------------------------
// calculate_layer3_sdiv_seq
//   Iterative signed integer divider (C truncating semantics) that rescales
//   accumulated layer-3 products back to fixed-point scale. Magnitudes are
//   divided with a radix-2 restoring loop, signs are applied in a final
//   fix-up cycle. Fixed latency; a global clock enable stalls everything.
// Ports
//   clk          in   1    rising-edge clock
//   reset        in   1    synchronous, active-high
//   ce           in   1    clock enable; low freezes all state and outputs
//   start        in   1    request, accepted on a ce edge while ready=1
//   dividend     in   DIVIDEND_WIDTH  signed, sampled on the accept edge
//   divisor      in   DIVISOR_WIDTH   signed, sampled on the accept edge
//   ready        out  1    idle, can accept start
//   done         out  1    one-ce-cycle pulse, results valid
//   quotient     out  DIVIDEND_WIDTH  signed, held until the next result
//   remainder    out  DIVISOR_WIDTH   signed, held until the next result
//   div_by_zero  out  1    divisor was zero (held with the result)
//   overflow     out  1    quotient saturated (held with the result)
// ---------------------------------------------------------------------------
module calculate_layer3_sdiv_seq
  import calc_div_pkg::*;
#(
  parameter int DIVIDEND_WIDTH = DIVIDEND_WIDTH_DEF,
  parameter int DIVISOR_WIDTH  = DIVISOR_WIDTH_DEF
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             ce,
  input  logic                             start,
  input  logic signed [DIVIDEND_WIDTH-1:0] dividend,
  input  logic signed [DIVISOR_WIDTH-1:0]  divisor,
  output logic                             ready,
  output logic                             done,
  output logic signed [DIVIDEND_WIDTH-1:0] quotient,
  output logic signed [DIVISOR_WIDTH-1:0]  remainder,
  output logic                             div_by_zero,
  output logic                             overflow
);

  localparam int            QW       = DIVIDEND_WIDTH;
  localparam int            RW       = DIVISOR_WIDTH;
  localparam int            CW       = cnt_width(QW);
  localparam logic [CW-1:0] CNT_LOAD = CW'(QW - 1);
  localparam logic [QW-1:0] Q_MAX    = {1'b0, {(QW-1){1'b1}}};

  state_t        state, next_state;
  logic          accept, fix_en;
  logic [CW-1:0] cnt;

  // Working registers (unsigned magnitudes plus latched signs).
  logic [RW-1:0] rem_q, rem_next;
  logic [QW-1:0] quo_q, quo_next;
  logic [RW-1:0] dvs_mag_q;
  logic          dvd_neg_q, quo_neg_q, dbz_q;

  // Input magnitudes. -2^(QW-1) negates to itself, which read as unsigned
  // is exactly 2^(QW-1): no information is lost.
  logic [QW-1:0] dvd_mag;
  logic [RW-1:0] dvs_mag;

  // Sign fix-up results.
  logic [QW-1:0] quo_fix;
  logic [RW-1:0] rem_fix;
  logic          ovf_fix;

  assign ready = (state == S_IDLE);

  always_comb begin
    dvd_mag = dividend[QW-1] ? -dividend : dividend;
    dvs_mag = divisor[RW-1]  ? -divisor  : divisor;
  end

  // ---------------------------------------------------------------- control
  // NOTE: clocked processes use non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else if (ce) begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    fix_en     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          next_state = S_ITER;
        end
      end
      S_ITER: begin
        if (cnt == '0) next_state = S_FIX;
      end
      S_FIX: begin
        fix_en     = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  calculate_layer3_sdiv_step #(
    .QW (QW),
    .RW (RW)
  ) u_step (
    .rem_in      (rem_q),
    .quo_in      (quo_q),
    .divisor_mag (dvs_mag_q),
    .rem_out     (rem_next),
    .quo_out     (quo_next)
  );

  // With a zero divisor every step "fits" and keeps the shifted bits, so the
  // remainder register ends up holding |dividend| mod 2^RW; re-applying the
  // dividend sign yields dividend[RW-1:0] with no special path.
  always_comb begin
    quo_fix = quo_neg_q ? -quo_q : quo_q;
    rem_fix = dvd_neg_q ? -rem_q : rem_q;
    ovf_fix = 1'b0;
    if (dbz_q) begin
      quo_fix = '0;
    end else if (!quo_neg_q && quo_q[QW-1]) begin
      // Only -2^(QW-1) / -1 reaches here: +2^(QW-1) is not representable.
      quo_fix = Q_MAX;
      ovf_fix = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_mag_q   <= '0;
      dvd_neg_q   <= 1'b0;
      quo_neg_q   <= 1'b0;
      dbz_q       <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else if (ce) begin
      // done is high for exactly one ce cycle after the FIX edge.
      done <= fix_en;

      if (accept) begin
        rem_q     <= '0;
        quo_q     <= dvd_mag;
        dvs_mag_q <= dvs_mag;
        dvd_neg_q <= dividend[QW-1];
        quo_neg_q <= dividend[QW-1] ^ divisor[RW-1];
        dbz_q     <= (divisor == '0);
        cnt       <= CNT_LOAD;
      end

      if (state == S_ITER) begin
        rem_q <= rem_next;
        quo_q <= quo_next;
        if (cnt != '0) cnt <= cnt - CW'(1);
      end

      if (fix_en) begin
        quotient    <= quo_fix;
        remainder   <= rem_fix;
        div_by_zero <= dbz_q;
        overflow    <= ovf_fix;
      end
    end
  end

endmodule : calculate_layer3_sdiv_seq
